// File: rtl/fp_div_arbiter_pkg.sv
// Shared types for the FP32 divider arbiter: tag layout, status flags, arbiter FSM states.
package rtacc_div_pkg;
  localparam int FP_W   = 32;
  localparam int FLAG_W = 5;

  typedef logic [FLAG_W-1:0] fp_flags_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_HOLD = 2'd2
  } arb_state_t;

  // Tag layout for the default build (4 requesters, 5-bit tag): sequence number above requester id
  localparam int DEF_ID_W  = 2;
  localparam int DEF_SEQ_W = 3;

  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [DEF_ID_W-1:0]  id;
  } div_tag_t;
endpackage

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_any
);
  logic [IW:0] w_idx;

  always_comb begin
    w_idx    = '0;
    o_any    = 1'b0;
    o_gnt_id = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_idx >= (IW+1)'(N)) w_idx = w_idx - (IW+1)'(N);
      if (!o_any && i_req[w_idx[IW-1:0]]) begin
        o_any    = 1'b1;
        o_gnt_id = w_idx[IW-1:0];
      end
    end
    o_gnt = o_any ? (N'(1) << o_gnt_id) : '0;
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one FP32 divider among NUM_REQ requesters: round-robin grant, registered issue,
// in-flight credit limit, tag-routed responses and a drain handshake.
module fp_div_arbiter
  import rtacc_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int MAX_OUT = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][FP_W-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][FP_W-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [FP_W-1:0]               rsp_data_o,
  output fp_flags_t                     rsp_flags_o,
  output logic                          div_valid_o,
  input  logic                          div_ready_i,
  output logic [FP_W-1:0]               div_a_o,
  output logic [FP_W-1:0]               div_b_o,
  output logic [TAG_W-1:0]              div_tag_o,
  input  logic                          div_valid_i,
  input  logic [FP_W-1:0]               div_result_i,
  input  fp_flags_t                     div_flags_i,
  input  logic [TAG_W-1:0]              div_tag_i,
  input  logic                          drain_i,
  output logic                          drain_done_o,
  output logic                          busy_o,
  output logic                          err_o
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SEQ_W = TAG_W - ID_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [SEQ_W-1:0]    r_seq;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_div_vld;
  logic [FP_W-1:0]     r_div_a, r_div_b;
  logic [TAG_W-1:0]    r_div_tag;
  logic [NUM_REQ-1:0]  r_rsp_vld;
  logic [FP_W-1:0]     r_rsp_data;
  fp_flags_t           r_rsp_flags;
  logic                r_done, r_err;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_id, w_tag_id;
  logic                w_any, w_run, w_done_set;
  logic                w_issue_free, w_grant_en, w_accept;
  logic                w_dec, w_no_cnt, w_bad_id, w_rsp_ok;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .i_req    (req_valid_i),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  assign w_issue_free = !r_div_vld || div_ready_i;
  assign w_grant_en   = w_issue_free && (r_cnt < CNT_W'(MAX_OUT));
  assign w_accept     = w_run && w_grant_en && w_any;

  assign w_tag_id = div_tag_i[ID_W-1:0];
  assign w_no_cnt = div_valid_i && (r_cnt == '0);
  assign w_bad_id = ({1'b0, w_tag_id} >= (ID_W+1)'(NUM_REQ));
  assign w_dec    = div_valid_i && (r_cnt != '0);
  assign w_rsp_ok = w_dec && !w_bad_id;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:        if (drain_i) w_state_nxt = DRAIN;
      DRAIN:      if (r_cnt == '0) w_state_nxt = drain_i ? DRAIN_HOLD : RUN;
      DRAIN_HOLD: if (!drain_i) w_state_nxt = RUN;
      default:    w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run       = (r_state == RUN);
    w_done_set  = (r_state == DRAIN) && (r_cnt == '0);
    req_ready_o = (w_run && w_grant_en) ? w_gnt : '0;
  end

  // Issue register holds operands stable until the divider takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_vld <= 1'b0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_div_tag <= '0;
      r_seq     <= '0;
      r_ptr     <= '0;
    end else if (w_accept) begin
      r_div_vld <= 1'b1;
      r_div_a   <= req_a_i[w_gnt_id];
      r_div_b   <= req_b_i[w_gnt_id];
      r_div_tag <= {r_seq, w_gnt_id};
      r_seq     <= r_seq + SEQ_W'(1);
      r_ptr     <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
    end else if (div_ready_i) begin
      r_div_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && !w_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_accept && w_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Unexpected or misrouted returns are dropped; only reset clears the error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld   <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_vld <= w_rsp_ok ? (NUM_REQ'(1) << w_tag_id) : '0;
      if (w_rsp_ok) begin
        r_rsp_data  <= div_result_i;
        r_rsp_flags <= div_flags_i;
      end
      r_done <= w_done_set;
      r_err  <= r_err | w_no_cnt | (div_valid_i && w_bad_id);
    end
  end

  assign div_valid_o  = r_div_vld;
  assign div_a_o      = r_div_a;
  assign div_b_o      = r_div_b;
  assign div_tag_o    = r_div_tag;
  assign rsp_valid_o  = r_rsp_vld;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_flags_o  = r_rsp_flags;
  assign drain_done_o = r_done;
  assign busy_o       = (r_cnt != '0);
  assign err_o        = r_err;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: divider stub with fixed latency, scoreboard of routed quotients.
module tb_fp_div_arbiter;
  import rtacc_div_pkg::*;
  localparam int N = 4, TW = 5, MO = 6, IW = 2, NV = 8;

  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N-1:0][31:0] req_a, req_b;
  logic [31:0] rsp_data, div_a, div_b, div_res;
  logic [4:0] rsp_flags, div_fl;
  logic div_valid_o, div_ready, div_valid_in;
  logic [TW-1:0] div_tag_o, div_tag_in;
  logic drain, drain_done, busy, err;

  logic [2:0] u3_req_valid, u3_req_ready, u3_rsp_valid;
  logic [2:0][31:0] u3_req_a, u3_req_b;
  logic [31:0] u3_rsp_data, u3_div_a, u3_div_b;
  logic [4:0] u3_rsp_flags;
  logic u3_div_valid_o, u3_div_ready, u3_dvi, u3_drain_done, u3_busy, u3_err;
  logic [TW-1:0] u3_div_tag_o, u3_dtag;

  always #5 clk = ~clk;

  fp_div_arbiter #(.NUM_REQ(N), .TAG_W(TW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_flags_o(rsp_flags), .div_valid_o(div_valid_o), .div_ready_i(div_ready),
    .div_a_o(div_a), .div_b_o(div_b), .div_tag_o(div_tag_o), .div_valid_i(div_valid_in),
    .div_result_i(div_res), .div_flags_i(div_fl), .div_tag_i(div_tag_in), .drain_i(drain),
    .drain_done_o(drain_done), .busy_o(busy), .err_o(err));

  fp_div_arbiter #(.NUM_REQ(3), .TAG_W(TW), .MAX_OUT(MO)) u3 (
    .clk(clk), .rst(rst), .req_valid_i(u3_req_valid), .req_ready_o(u3_req_ready),
    .req_a_i(u3_req_a), .req_b_i(u3_req_b), .rsp_valid_o(u3_rsp_valid), .rsp_data_o(u3_rsp_data),
    .rsp_flags_o(u3_rsp_flags), .div_valid_o(u3_div_valid_o), .div_ready_i(u3_div_ready),
    .div_a_o(u3_div_a), .div_b_o(u3_div_b), .div_tag_o(u3_div_tag_o), .div_valid_i(u3_dvi),
    .div_result_i(32'h3F800000), .div_flags_i(5'h0), .div_tag_i(u3_dtag), .drain_i(1'b0),
    .drain_done_o(u3_drain_done), .busy_o(u3_busy), .err_o(u3_err));

  typedef struct { logic [31:0] a, b, q; logic [4:0] fl; } vec_t;
  typedef struct { int id; logic [31:0] q; logic [4:0] fl; } exp_t;
  typedef struct { int due; logic [TW-1:0] tag; logic [31:0] q; logic [4:0] fl; } mq_t;

  vec_t vt[NV];
  exp_t sb[$];
  mq_t  mq[$];
  int   cur[N];
  int   glog[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, lat = 2, ret_budget = 1000000, acc_cnt = 0, last_rsp_cyc = -1;
  bit   exp_rsp = 0, inj = 0;
  logic [TW-1:0] inj_tag;
  logic [N-1:0]  last_acc;
  logic [2:0]    seq_exp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [4:0] fl);
    q = a ^ b; fl = 5'h0;
    for (int i = 0; i < NV; i++)
      if (vt[i].a == a && vt[i].b == b) begin q = vt[i].q; fl = vt[i].fl; end
  endtask

  // One clock: capture handshakes before the edge, check outputs after it, then drive the divider stub
  task automatic tick();
    logic [N-1:0] acc; bit hs; logic [TW-1:0] htag; logic [31:0] ha, hb, aa, ab;
    int aid; exp_t e; mq_t m;
    #1;
    acc = req_valid & req_ready;
    hs = div_valid_o && div_ready;
    htag = div_tag_o; ha = div_a; hb = div_b;
    aid = -1; aa = '0; ab = '0;
    for (int i = 0; i < N; i++) if (acc[i]) begin aid = i; aa = req_a[i]; ab = req_b[i]; end
    if (acc != '0) begin
      acc_cnt++;
      chk("ready_onehot", 64'($countones(acc)), 1);
      e.id = aid; lookup(aa, ab, e.q, e.fl); sb.push_back(e);
    end
    @(posedge clk); #1; cyc++;
    if (aid >= 0) begin
      chk("issue_valid", div_valid_o, 1);
      chk("issue_tag", div_tag_o, {seq_exp, 2'(aid)});
      chk("issue_a", div_a, aa);
      chk("issue_b", div_b, ab);
      seq_exp++;
      glog.push_back(aid); last_acc = acc;
      cur[aid] = (cur[aid] + 1) % NV;
      req_a[aid] = vt[cur[aid]].a; req_b[aid] = vt[cur[aid]].b;
    end
    if (exp_rsp || rsp_valid != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, N'(1) << e.id);
        chk("rsp_data", rsp_data, e.q);
        chk("rsp_flags", rsp_flags, e.fl);
        last_rsp_cyc = cyc;
      end
    end
    if (hs) begin m.due = cyc + lat; m.tag = htag; lookup(ha, hb, m.q, m.fl); mq.push_back(m); end
    if (inj) begin
      div_valid_in = 1'b1; div_tag_in = inj_tag; div_res = 32'hDEADBEEF; div_fl = 5'h1F;
      exp_rsp = 0; inj = 0;
    end else if (ret_budget > 0 && mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      div_valid_in = 1'b1; div_tag_in = m.tag; div_res = m.q; div_fl = m.fl;
      exp_rsp = 1; ret_budget--;
    end else begin
      div_valid_in = 1'b0; exp_rsp = 0;
    end
  endtask

  task automatic drain_sb(input int budget);
    int n = 0;
    while ((sb.size() > 0 || exp_rsp) && n < budget) begin tick(); n++; end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; drain = 1'b0; inj = 0; div_ready = 1'b1;
    u3_req_valid = '0; u3_dvi = 1'b0; u3_dtag = '0; u3_div_ready = 1'b1;
    sb.delete(); mq.delete(); exp_rsp = 0; div_valid_in = 1'b0;
    tick(); tick();
    rst = 1'b0; seq_exp = '0; sb.delete(); mq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dd_cnt, dd_cyc; bit bad; div_tag_t t; logic [TW-1:0] t0; logic [31:0] a0, b0;
    vt[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00};
    vt[1] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 5'h00};
    vt[2] = '{32'h41000000, 32'h40800000, 32'h40000000, 5'h00};
    vt[3] = '{32'h41100000, 32'h40400000, 32'h40400000, 5'h00};
    vt[4] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08};
    vt[5] = '{32'h41200000, 32'h40800000, 32'h40200000, 5'h00};
    vt[6] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01};
    vt[7] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10};
    for (int i = 0; i < N; i++) begin cur[i] = i; req_a[i] = vt[i].a; req_b[i] = vt[i].b; end
    for (int i = 0; i < 3; i++) begin u3_req_a[i] = 32'h40000000; u3_req_b[i] = 32'h3F800000; end
    div_res = '0; div_fl = '0; div_tag_in = '0; inj_tag = '0; last_acc = '0; seq_exp = '0;

    do_reset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_div_valid", div_valid_o, 0);
    chk("rst_div_tag", div_tag_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_drain_done", drain_done, 0);

    // single request from requester 0: 6/2
    cur[0] = 0; req_a[0] = vt[0].a; req_b[0] = vt[0].b;
    req_valid = 4'b0001; #1;
    chk("t1_ready_same_cycle", req_ready, 4'b0001);
    tick(); req_valid = '0;
    t = div_tag_o;
    chk("t1_tag_id", t.id, 0);
    chk("t1_busy", busy, 1);
    drain_sb(20);

    // table sweep, one requester at a time
    for (int k = 1; k < NV; k++) begin
      cur[k % N] = k; req_a[k % N] = vt[k].a; req_b[k % N] = vt[k].b;
      req_valid = N'(1) << (k % N); #1;
      chk("tbl_ready", req_ready, N'(1) << (k % N));
      tick(); req_valid = '0;
      drain_sb(20);
    end

    // all requesters held: strict rotation
    do_reset();
    glog.delete(); req_valid = '1;
    for (int i = 0; i < 8; i++) tick();
    req_valid = '0;
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk("rr_order", glog[i], i % N);
    drain_sb(30);

    // divider back-pressure: issue held stable, no grants, pointer frozen
    div_ready = 1'b0; req_valid = 4'b0010;
    tick();
    req_valid = '1; t0 = div_tag_o; a0 = div_a; b0 = div_b;
    for (int i = 0; i < 5; i++) begin
      #1; chk("bp_no_ready", req_ready, 0);
      tick();
      chk("bp_valid", div_valid_o, 1);
      chk("bp_tag", div_tag_o, t0);
      chk("bp_a", div_a, a0);
      chk("bp_b", div_b, b0);
    end
    last_acc = '0; div_ready = 1'b1;
    tick(); req_valid = '0;
    chk("bp_resume_ptr", last_acc, 4'b0100);
    drain_sb(30);

    // credit limit with a divider that holds everything
    do_reset();
    ret_budget = 0; acc_cnt = 0; req_valid = '1;
    for (int i = 0; i < 12; i++) tick();
    chk("cred_accepts", acc_cnt, MO);
    #1; chk("cred_stall_ready", req_ready, 0);
    chk("cred_busy", busy, 1);
    ret_budget = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("cred_refill", acc_cnt, MO + 1);
    req_valid = '0; ret_budget = 1000000;
    drain_sb(60);

    // drain with three ops in flight
    lat = 6; acc_cnt = 0; req_valid = '1;
    for (int i = 0; i < 3; i++) tick();
    req_valid = '0; drain = 1'b1;
    tick();
    req_valid = '1; bad = 0; dd_cnt = 0; dd_cyc = -100;
    for (int i = 0; i < 30; i++) begin
      #1; if (req_ready != '0) bad = 1;
      tick();
      if (drain_done) begin dd_cnt++; dd_cyc = cyc; end
    end
    chk("drain_accepts", acc_cnt, 3);
    chk("drain_no_ready", bad, 0);
    chk("drain_done_once", dd_cnt, 1);
    chk("drain_done_timing", dd_cyc, last_rsp_cyc + 1);
    chk("drain_sb_empty", sb.size(), 0);
    drain = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("drain_resume", acc_cnt, 2);
    req_valid = '0;
    drain_sb(40);
    lat = 2;

    // response with nothing outstanding
    chk("err_pre", err, 0);
    inj = 1; inj_tag = 5'b00001;
    tick(); tick();
    chk("err_nocnt", err, 1);
    chk("err_nocnt_rsp", rsp_valid, 0);
    chk("err_nocnt_busy", busy, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);

    // out-of-range requester id on a 3-requester build
    u3_req_valid = 3'b001;
    tick(); u3_req_valid = '0;
    chk("u3_issue", u3_div_valid_o, 1);
    tick();
    chk("u3_busy", u3_busy, 1);
    chk("u3_err_pre", u3_err, 0);
    u3_dvi = 1'b1; u3_dtag = 5'b00011;
    tick(); u3_dvi = 1'b0;
    chk("u3_bad_rsp", u3_rsp_valid, 0);
    chk("u3_bad_err", u3_err, 1);
    chk("u3_bad_count", u3_busy, 0);
    tick();
    chk("u3_bad_rsp_late", u3_rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
